// File: rtl/uart_tx_parity.sv
// Buffered 8E1 UART transmitter: FIFO -> frame FSM -> registered line. Line goes low 2 cycles after a push into an idle TX.
// Backpressure: tx_ready drops while the FIFO is full; held bytes are accepted as frames drain.

module uart_tx_parity_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_vld,
   output logic                   push_rdy,
   input  logic [WIDTH-1:0]       push_dat,
   output logic                   pop_vld,
   input  logic                   pop_rdy,
   output logic [WIDTH-1:0]       pop_dat,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_parity_fifo: DEPTH must be a power of 2 and >= 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_cnt_q, wr_cnt_d;
   logic [AW:0]      rd_cnt_q, rd_cnt_d;
   logic             push, pop;

   // Counters carry one extra wrap bit so full and empty stay distinguishable.
   assign level    = wr_cnt_q - rd_cnt_q;
   assign push_rdy = (level != (AW + 1)'(DEPTH));
   assign pop_vld  = (level != '0);
   assign pop_dat  = mem_q[rd_cnt_q[AW-1:0]];
   assign push     = push_vld && push_rdy;
   assign pop      = pop_rdy && pop_vld;

   always_comb begin
      mem_d    = mem_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (push) begin
         mem_d[wr_cnt_q[AW-1:0]] = push_dat;
         wr_cnt_d = wr_cnt_q + (AW + 1)'(1);
      end
      if (pop) begin
         rd_cnt_d = rd_cnt_q + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

module uart_tx_parity #(
   parameter int CLK_FREQ_HZ   = 70_000_000,
   parameter int UART_BAUDRATE = 1_000_000,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                        sys_clk,
   input  logic                        sys_rstn,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        uart_rxd_out
);
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / UART_BAUDRATE;
   localparam int BAUD_W       = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_parity: CLK_FREQ_HZ/UART_BAUDRATE must be >= 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              parity_q, parity_d;
   logic              line_q, line_d;

   logic              fifo_vld;
   logic              fifo_pop;
   logic [7:0]        fifo_dat;
   logic              baud_last;

   uart_tx_parity_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (sys_clk),
      .rst_n    (sys_rstn),
      .push_vld (tx_valid),
      .push_rdy (tx_ready),
      .push_dat (tx_data),
      .pop_vld  (fifo_vld),
      .pop_rdy  (fifo_pop),
      .pop_dat  (fifo_dat),
      .level    (fifo_level)
   );

   assign baud_last    = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign tx_busy      = (state_q != ST_IDLE) || fifo_vld;
   assign uart_rxd_out = line_q;

   // Line level is derived from the current state and registered, so the
   // line trails the FSM by one cycle and never glitches.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      line_d     = 1'b1;
      fifo_pop   = 1'b0;

      if (state_q != ST_IDLE) begin
         baud_cnt_d = baud_last ? '0 : baud_cnt_q + BAUD_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            line_d = 1'b1;
            if (fifo_vld) begin
               fifo_pop   = 1'b1;
               shift_d    = fifo_dat;
               parity_d   = ^fifo_dat;
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            line_d = 1'b0;
            if (baud_last) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            line_d = shift_q[0];
            if (baud_last) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            line_d = parity_q;
            if (baud_last) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            line_d = 1'b1;
            // Chain straight into the next start bit when more data is queued.
            if (baud_last) begin
               if (fifo_vld) begin
                  fifo_pop  = 1'b1;
                  shift_d   = fifo_dat;
                  parity_d  = ^fifo_dat;
                  bit_cnt_d = '0;
                  state_d   = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rstn) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         line_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         line_q     <= line_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: frame-position reference model plus an independent serial decoder.
module tb_uart_tx_parity;
   localparam int C     = 70;
   localparam int FR    = 11 * C;
   localparam int DEPTH = 16;

   logic       sys_clk = 1'b0;
   logic       sys_rstn;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic [4:0] fifo_level;
   logic       uart_rxd_out;

   uart_tx_parity #(
      .CLK_FREQ_HZ   (70_000_000),
      .UART_BAUDRATE (1_000_000),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rstn     (sys_rstn),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_busy      (tx_busy),
      .fifo_level   (fifo_level),
      .uart_rxd_out (uart_rxd_out)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
         if (n_fail >= 40) begin
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
            $finish;
         end
      end
   endtask

   // Reference model: queue of pending bytes and position within the current frame.
   logic [7:0] m_q[$];
   logic [7:0] exp_tx[$];
   logic [7:0] m_cur = 8'h00;
   int         m_fr   = -1;
   logic       m_line = 1'b1;
   logic       m_acc  = 1'b0;
   int         m_sent = 0;

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic model_edge(input logic v, input logic [7:0] d, input logic rn);
      logic rdy;
      if (!rn) begin
         m_sent -= exp_tx.size();
         m_q.delete();
         exp_tx.delete();
         m_fr   = -1;
         m_line = 1'b1;
         m_acc  = 1'b0;
      end else begin
         rdy    = (m_q.size() < DEPTH);
         m_line = (m_fr >= 0) ? frame_bit(m_cur, m_fr / C) : 1'b1;
         if (m_fr == FR - 1) m_fr = -1;
         else if (m_fr >= 0) m_fr++;
         if (m_fr == -1 && m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            exp_tx.push_back(m_cur);
            m_sent++;
            m_fr = 0;
         end
         m_acc = v && rdy;
         if (m_acc) m_q.push_back(d);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic rn);
      tx_valid = v;
      tx_data  = d;
      sys_rstn = rn;
      @(posedge sys_clk);
      model_edge(v, d, rn);
      #1;
      chk("line", 32'(uart_rxd_out), 32'(m_line));
      chk("ready", 32'(tx_ready), 32'(m_q.size() < DEPTH));
      chk("level", 32'(fifo_level), 32'(m_q.size()));
      chk("busy", 32'(tx_busy), 32'(m_fr >= 0 || m_q.size() > 0));
   endtask

   task automatic push_hold(input logic [7:0] d);
      int n = 0;
      do begin
         step(1'b1, d, 1'b1);
         n++;
      end while (!m_acc && n < 20000);
      chk("push_timeout", 32'(m_acc), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((m_fr >= 0 || m_q.size() > 0) && n < 30000) begin
         step(1'b0, 8'h00, 1'b1);
         n++;
      end
      chk("drain_timeout", 32'(n < 30000), 32'd1);
      repeat (C) step(1'b0, 8'h00, 1'b1);
   endtask

   // Independent serial decoder sampling mid-bit on the falling clock edge.
   logic        d_prev = 1'b1;
   logic        d_act  = 1'b0;
   int          d_cnt  = 0;
   int          dec_n  = 0;
   logic [10:0] d_bits = '0;

   always @(negedge sys_clk) begin
      if (sys_rstn !== 1'b1) begin
         d_act = 1'b0;
      end else if (!d_act) begin
         if (d_prev && !uart_rxd_out) begin
            d_act = 1'b1;
            d_cnt = 0;
         end
      end else begin
         d_cnt++;
         if (d_cnt % C == C / 2) begin
            d_bits[d_cnt / C] = uart_rxd_out;
            if (d_cnt / C == 10) begin
               d_act = 1'b0;
               dec_n++;
               chk("dec_start", 32'(d_bits[0]), 32'd0);
               chk("dec_parity", 32'(d_bits[9]), 32'(^d_bits[8:1]));
               chk("dec_stop", 32'(d_bits[10]), 32'd1);
               if (exp_tx.size() == 0) chk("dec_unexpected", 32'd1, 32'd0);
               else chk("dec_byte", 32'(d_bits[8:1]), 32'(exp_tx.pop_front()));
            end
         end
      end
      d_prev = uart_rxd_out;
   end

   initial begin
      #(10 * 200_000);
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         n;
      logic       full_seen;

      sys_rstn = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) step(1'b0, 8'h00, 1'b0);
      chk("rst_line", 32'(uart_rxd_out), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_busy", 32'(tx_busy), 32'd0);

      // Single byte from idle: line high one more cycle, then start bit.
      step(1'b1, 8'hA5, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("t1_line_n1", 32'(uart_rxd_out), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      chk("t1_line_n2", 32'(uart_rxd_out), 32'd0);
      drain();

      step(1'b1, 8'h01, 1'b1);
      step(1'b1, 8'h7F, 1'b1);
      drain();

      // Hold valid with 20 bytes; FIFO must fill and stall.
      full_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         n = 0;
         do begin
            step(1'b1, 8'(i), 1'b1);
            n++;
            if (!full_seen && m_q.size() == DEPTH) begin
               full_seen = 1'b1;
               chk("t3_full_level", 32'(fifo_level), 32'd16);
               chk("t3_full_ready", 32'(tx_ready), 32'd0);
            end
         end while (!m_acc && n < 20000);
         chk("t3_push_timeout", 32'(m_acc), 32'd1);
      end
      chk("t3_full_seen", 32'(full_seen), 32'd1);
      drain();

      step(1'b1, 8'h00, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'h55, 1'b1);
      drain();

      // Push on the last stop cycle while one byte is queued.
      step(1'b1, 8'h3A, 1'b1);
      step(1'b1, 8'hC4, 1'b1);
      n = 0;
      while (m_fr != FR - 1 && n < 2000) begin
         step(1'b0, 8'h00, 1'b1);
         n++;
      end
      chk("t6_reach_stop", 32'(m_fr), 32'(FR - 1));
      step(1'b1, 8'h96, 1'b1);
      chk("t6_level", 32'(fifo_level), 32'd1);
      drain();

      // Reset mid-DATA with three bytes queued.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b1);
      n = 0;
      while (m_fr != 3 * C && n < 2000) begin
         step(1'b0, 8'h00, 1'b1);
         n++;
      end
      chk("t5_level_pre", 32'(fifo_level), 32'd3);
      step(1'b0, 8'h00, 1'b0);
      chk("t5_line", 32'(uart_rxd_out), 32'd1);
      chk("t5_level", 32'(fifo_level), 32'd0);
      chk("t5_ready", 32'(tx_ready), 32'd1);
      chk("t5_busy", 32'(tx_busy), 32'd0);
      repeat (2 * FR) step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h3C, 1'b1);
      drain();

      // Random bytes with a mix of back-to-back and idle-gapped writes.
      for (int i = 0; i < 12; i++) begin
         n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 900)) : 0;
         repeat (n) step(1'b0, 8'h00, 1'b1);
         b = 8'($urandom);
         push_hold(b);
      end
      drain();

      chk("exp_empty", 32'(exp_tx.size()), 32'd0);
      chk("dec_count", 32'(dec_n), 32'(m_sent));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
